// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - interleaved RGB stream to planar, two-samples-per-word SRAM image writer
module frame_loader #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic [9:0]        iCol_Max,
    input  logic [9:0]        iRow_Max,
    input  logic              iPix_valid,
    input  logic [7:0]        iR,
    input  logic [7:0]        iG,
    input  logic [7:0]        iB,
    output logic              oPix_ready,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    inout  wire  [DATA_W-1:0] oSRAM_DATA,
    output logic              oBusy,
    output logic              oStart_transform
);

    typedef enum logic [2:0] {
        S_IDLE, S_GATH0, S_GATH1, S_WR_R, S_WR_G, S_WR_B, S_FINISH
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_p;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we_n;
    logic              r_ready;
    logic              r_busy;
    logic              r_start;
    logic [7:0]        r_r0, r_g0, r_b0, r_g1, r_b1;

    logic [19:0]       w_prod;
    logic [ADDR_W-1:0] w_stride;
    logic              w_xfer;

    assign w_prod   = 20'(iCol_Max) * 20'(iRow_Max);
    assign w_stride = ADDR_W'(w_prod >> 1);
    assign w_xfer   = iPix_valid & r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_stride <= '0;
            r_p      <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_we_n   <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_r0     <= '0;
            r_g0     <= '0;
            r_b0     <= '0;
            r_g1     <= '0;
            r_b1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_load) begin
                        r_stride <= w_stride;
                        if (w_stride == '0) begin
                            r_start <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_p     <= '0;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_GATH0;
                        end
                    end
                end
                S_GATH0: begin
                    if (w_xfer) begin
                        r_r0    <= iR;
                        r_g0    <= iG;
                        r_b0    <= iB;
                        r_state <= S_GATH1;
                    end
                end
                S_GATH1: begin
                    // The R word is assembled straight from the odd pixel so the write issues next cycle
                    if (w_xfer) begin
                        r_g1    <= iG;
                        r_b1    <= iB;
                        r_ready <= 1'b0;
                        r_we_n  <= 1'b0;
                        r_addr  <= r_p;
                        r_data  <= DATA_W'({r_r0, iR});
                        r_state <= S_WR_R;
                    end
                end
                S_WR_R: begin
                    r_addr  <= r_addr + r_stride;
                    r_data  <= DATA_W'({r_g0, r_g1});
                    r_state <= S_WR_G;
                end
                S_WR_G: begin
                    r_addr  <= r_addr + r_stride;
                    r_data  <= DATA_W'({r_b0, r_b1});
                    r_state <= S_WR_B;
                end
                S_WR_B: begin
                    r_we_n <= 1'b1;
                    if (r_p == r_stride - 1'b1) begin
                        r_busy  <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_p     <= r_p + 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_GATH0;
                    end
                end
                S_FINISH: begin
                    r_start <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oPix_ready       = r_ready;
    assign oSRAM_OE_N       = 1'b1;
    assign oSRAM_WE_N       = r_we_n;
    assign oSRAM_ADDR       = r_addr;
    assign oSRAM_DATA       = r_we_n ? {DATA_W{1'bz}} : r_data;
    assign oBusy            = r_busy;
    assign oStart_transform = r_start;

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - scoreboard bench for frame_loader
module tb_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n, start_load, valid;
    logic [9:0]  col, row;
    logic [7:0]  pr, pg, pb;
    wire         ready, oe_n, we_n, busy, stp;
    wire  [19:0] addr;
    wire  [15:0] sdata;

    always #5 clk = ~clk;

    frame_loader #(.ADDR_W(20), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load),
        .iCol_Max(col), .iRow_Max(row), .iPix_valid(valid),
        .iR(pr), .iG(pg), .iB(pb), .oPix_ready(ready),
        .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n), .oSRAM_ADDR(addr),
        .oSRAM_DATA(sdata), .oBusy(busy), .oStart_transform(stp)
    );

    typedef struct packed { logic [19:0] a; logic [15:0] d; } wr_t;
    wr_t sb[$];

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, start_cyc = 0, pulse_cnt = 0, pulse_cyc = 0, wr_cnt = 0;
    logic [19:0] last_addr = '0;
    bit ready_seen = 0;

    // 4x2 frame, pixel n = (n, 0x10+n, 0x20+n)
    logic [19:0] t_addr [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    logic [15:0] t_data [12] = '{16'h0001, 16'h1011, 16'h2021, 16'h0203, 16'h1213, 16'h2223,
                                 16'h0405, 16'h1415, 16'h2425, 16'h0607, 16'h1617, 16'h2627};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_evt(string name);
        total_cnt++;
        $display("FAIL %s: got no event expected event", name);
    endtask

    function automatic logic [23:0] pix(int mode, int n);
        logic [7:0] v;
        v = n[7:0];
        if (mode == 0) return {v, 8'h10 + v, 8'h20 + v};
        return {v, 8'(n * 3), 8'(n >> 3) ^ 8'h5a};
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (stp === 1'b1) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
        if (ready === 1'b1) ready_seen = 1;
        if (we_n === 1'b0) begin
            wr_cnt++;
            last_addr = addr;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr %0d expected no write", addr);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(addr), 32'(e.a));
                check("wr_data", 32'(sdata), 32'(e.d));
            end
        end
    end

    task automatic push_table(int cnt);
        for (int i = 0; i < cnt; i++) sb.push_back({t_addr[i], t_data[i]});
    endtask

    task automatic push_model(int mode, int s, int npairs);
        logic [23:0] a, b;
        for (int p = 0; p < npairs; p++) begin
            a = pix(mode, 2 * p);
            b = pix(mode, 2 * p + 1);
            sb.push_back({20'(p),         a[23:16], b[23:16]});
            sb.push_back({20'(s + p),     a[15:8],  b[15:8]});
            sb.push_back({20'(2 * s + p), a[7:0],   b[7:0]});
        end
    endtask

    task automatic start_frame(int c, int r);
        @(negedge clk);
        col = 10'(c);
        row = 10'(r);
        start_load = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic drive(int mode, int npix, bit gaps, int repulse_at, int stop_addr);
        int n = 0, t = 0;
        bit repulsed = 0;
        while (n < npix && t < 20000) begin
            @(negedge clk);
            t++;
            if (stop_addr >= 0 && we_n === 1'b0 && int'(addr) == stop_addr) break;
            start_load = (repulse_at >= 0 && n == repulse_at && !repulsed);
            if (start_load) repulsed = 1;
            valid = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            {pr, pg, pb} = pix(mode, n);
            if (valid && ready === 1'b1) n++;
        end
        if (t >= 20000) fail_evt("pixel_drive_timeout");
        if (stop_addr < 0) @(negedge clk);
        valid = 1'b0;
        start_load = 1'b0;
    endtask

    task automatic wait_done(int p0, int exp_len);
        int t = 0;
        while (pulse_cnt == p0 && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (pulse_cnt == p0) fail_evt("start_transform_timeout");
        else if (exp_len > 0) check("frame_time", 32'(pulse_cyc - start_cyc + 1), 32'(exp_len));
        repeat (3) @(negedge clk);
        check("pulse_count", 32'(pulse_cnt - p0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outs();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(sdata), {16'h0, 16'hzzzz});
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(stp), 32'd0);
    endtask

    task automatic run_4x2(int repulse_at);
        int p0, w0;
        p0 = pulse_cnt;
        w0 = wr_cnt;
        push_table(12);
        start_frame(4, 2);
        drive(0, 8, 0, repulse_at, -1);
        wait_done(p0, 22);
        check("wr_count_4x2", 32'(wr_cnt - w0), 32'd12);
    endtask

    initial begin
        int p0, w0, t;
        rst_n = 1'b0; start_load = 1'b0; valid = 1'b0;
        col = '0; row = '0; pr = '0; pg = '0; pb = '0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst_n = 1'b1;

        run_4x2(-1);

        p0 = pulse_cnt;
        w0 = wr_cnt;
        push_model(1, 600, 600);
        start_frame(40, 30);
        drive(1, 1200, 1, -1, -1);
        wait_done(p0, 0);
        check("wr_count_40x30", 32'(wr_cnt - w0), 32'd1800);
        check("last_addr_40x30", 32'(last_addr), 32'd1799);

        p0 = pulse_cnt;
        w0 = wr_cnt;
        ready_seen = 0;
        start_frame(0, 30);
        @(negedge clk);
        start_load = 1'b0;
        wait_done(p0, 2);
        check("zero_writes", 32'(wr_cnt - w0), 32'd0);
        check("zero_ready_seen", 32'(ready_seen), 32'd0);

        run_4x2(6);

        p0 = pulse_cnt;
        push_table(5);
        start_frame(4, 2);
        drive(0, 8, 0, -1, 5);
        check("busy_mid", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outs();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_pulse", 32'(pulse_cnt), 32'(p0));
        check("rst_sb_empty", 32'(sb.size()), 32'd0);
        run_4x2(-1);

        push_model(1, 522242, 1);
        start_frame(1022, 1022);
        drive(1, 2, 0, -1, -1);
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("big_first_pair", 32'(sb.size()), 32'd0);
        check("big_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
